te_branch_map: RTL

TE_BRANCH_MAP -- requirements
Module: te_branch_map

---
 rtl/mure_pkg.sv | 4 +
 rtl/te_branch_map.sv | 69 ++++++
 2 files changed

// File: rtl/mure_pkg.sv
// Shared encoder-wide constants for the trace encoder blocks.
package mure_pkg;
    localparam int ITYPE_LEN = 3;
endpackage

// File: rtl/te_branch_map.sv
// Branch map accumulator: records taken/not-taken outcomes of retired branches
// until the encoder flushes them into a packet.
module te_branch_map #(
    parameter int MapLen = 31,
    parameter int CntW   = $clog2(MapLen + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    input  logic [mure_pkg::ITYPE_LEN-1:0] itype_i,
    input  logic                           flush_i,
    output logic [MapLen-1:0]              map_o,
    output logic [CntW-1:0]                branches_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           overflow_o
);

    localparam logic [mure_pkg::ITYPE_LEN-1:0] ItNotTaken = mure_pkg::ITYPE_LEN'(4);
    localparam logic [mure_pkg::ITYPE_LEN-1:0] ItTaken    = mure_pkg::ITYPE_LEN'(5);
    localparam logic [CntW-1:0]                CntMax     = CntW'(MapLen);

    logic [MapLen-1:0] map_q, map_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              is_branch;
    logic              not_taken;

    assign is_branch = valid_i && (itype_i == ItNotTaken || itype_i == ItTaken);
    assign not_taken = (itype_i == ItNotTaken);

    always_comb begin
        map_d = map_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (flush_i) begin
            // A branch arriving with the flush starts the fresh map at bit 0.
            map_d    = '0;
            map_d[0] = is_branch && not_taken;
            cnt_d    = is_branch ? CntW'(1) : '0;
        end else if (is_branch) begin
            if (cnt_q < CntMax) begin
                map_d[cnt_q] = not_taken;
                cnt_d        = cnt_q + CntW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign overflow_o = ovf_q;
    assign full_o     = (cnt_q == CntMax);
    assign empty_o    = (cnt_q == '0);

endmodule
